count_seq_ctrl: RTL and testbench

Sequencer that drives one 74LS191-style 4-bit up/down counter through its D/NLD/NCT/NUD inputs and watches its Q outputs.
- On a START command it loads a preset, counts up or down to a target, and repeats the pass LOOPS+1 times.
- It then signals DONE and returns to idle.
- It sits between control logic (or a test FSM) and the counter and is the only driver of the counter's control pins.

---
 rtl/count_seq_pkg.sv | 8 +
 rtl/register_74LS191.sv | 15 +
 rtl/count_seq_ctrl.sv | 95 +++++++++
 tb/tb_count_seq_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding, direction codes and default widths for the counter sequencer
package count_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COUNT, END} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LOOP_W = 4;
endpackage

// File: rtl/register_74LS191.sv
// register_74LS191: 4-bit up/down counter with asynchronous active-low parallel load
module register_74LS191 #(
  parameter int WIDTH = 4
) (
  input  logic             cp,
  input  logic [WIDTH-1:0] d,
  input  logic             nld,
  input  logic             nct,
  input  logic             nud,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge cp or negedge nld)
    if (!nld) q <= d;
    else if (!nct) q <= nud ? q - WIDTH'(1) : q + WIDTH'(1);
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: loads a preset into an external up/down counter and counts to a target, LOOPS+1 passes
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOOP_W = DEF_LOOP_W
) (
  input  logic              CP,
  input  logic              CLR,
  input  logic              START,
  input  logic              DIR,
  input  logic [WIDTH-1:0]  PRESET,
  input  logic [WIDTH-1:0]  TARGET,
  input  logic [LOOP_W-1:0] LOOPS,
  input  logic              HOLD,
  input  logic              ABORT,
  input  logic [WIDTH-1:0]  Q_IN,
  output logic [WIDTH-1:0]  D_OUT,
  output logic              NLD,
  output logic              NCT,
  output logic              NUD,
  output logic              BUSY,
  output logic              DONE,
  output logic [LOOP_W-1:0] PASS_CNT
);
  state_t state;
  logic dir_l;
  logic [WIDTH-1:0] preset_l, target_l, q_next;
  logic [LOOP_W-1:0] loops_l;
  // value the counter reaches at the next edge if it is stepping now
  assign q_next = (dir_l == DIR_DN) ? Q_IN - WIDTH'(1) : Q_IN + WIDTH'(1);
  always_ff @(posedge CP or posedge CLR)
    if (CLR) begin
      state    <= IDLE;
      NLD      <= 1'b1;
      NCT      <= 1'b1;
      NUD      <= DIR_UP;
      D_OUT    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS_CNT <= '0;
      dir_l    <= DIR_UP;
      preset_l <= '0;
      target_l <= '0;
      loops_l  <= '0;
    end else begin
      DONE <= 1'b0;
      if (state != IDLE && ABORT) begin
        state <= IDLE;
        NLD   <= 1'b1;
        NCT   <= 1'b1;
        BUSY  <= 1'b0;
      end else
        case (state)
          IDLE:
            if (START) begin
              dir_l    <= DIR;
              preset_l <= PRESET;
              target_l <= TARGET;
              loops_l  <= LOOPS;
              PASS_CNT <= '0;
              D_OUT    <= PRESET;
              NUD      <= DIR;
              NLD      <= 1'b0;
              NCT      <= 1'b1;
              BUSY     <= 1'b1;
              state    <= LOAD;
            end
          LOAD: begin
            NLD   <= 1'b1;
            NCT   <= (preset_l == target_l) ? 1'b1 : HOLD;
            state <= (preset_l == target_l) ? END : COUNT;
          end
          COUNT:
            if (!NCT && q_next == target_l) begin
              NCT   <= 1'b1;
              state <= END;
            end else
              NCT <= HOLD;
          END:
            if (PASS_CNT == loops_l) begin
              state    <= IDLE;
              DONE     <= 1'b1;
              BUSY     <= 1'b0;
              PASS_CNT <= (&loops_l) ? loops_l : loops_l + LOOP_W'(1);
            end else begin
              PASS_CNT <= PASS_CNT + LOOP_W'(1);
              D_OUT    <= preset_l;
              NLD      <= 1'b0;
              state    <= LOAD;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed sequences against the sequencer driving a real 74LS191 counter model
module tb_count_seq_ctrl;
  logic CP = 1'b0, CLR = 1'b0, START = 1'b0, DIR = 1'b0, HOLD = 1'b0, ABORT = 1'b0;
  logic [3:0] PRESET = '0, TARGET = '0, LOOPS = '0, q, d_out, pass_cnt;
  logic NLD, NCT, NUD, BUSY, DONE;
  int total = 0, bad = 0;
  int nlow, nld_cnt, ndone, done_at;
  logic [3:0] qs [0:15];

  count_seq_ctrl #(.WIDTH(4), .LOOP_W(4)) dut (
    .CP(CP), .CLR(CLR), .START(START), .DIR(DIR), .PRESET(PRESET), .TARGET(TARGET),
    .LOOPS(LOOPS), .HOLD(HOLD), .ABORT(ABORT), .Q_IN(q), .D_OUT(d_out), .NLD(NLD),
    .NCT(NCT), .NUD(NUD), .BUSY(BUSY), .DONE(DONE), .PASS_CNT(pass_cnt)
  );
  register_74LS191 #(.WIDTH(4)) u_cnt (
    .cp(CP), .d(d_out), .nld(NLD), .nct(NCT), .nud(NUD), .q(q)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CP);
    #1;
  endtask

  task automatic start_seq(input logic dir, input logic [3:0] pre, input logic [3:0] tgt, input logic [3:0] lp);
    DIR = dir; PRESET = pre; TARGET = tgt; LOOPS = lp; START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic run(input int n);
    nlow = 0; nld_cnt = 0; ndone = 0; done_at = -1;
    for (int i = 1; i <= n; i++) begin
      tick;
      qs[i] = q;
      nlow += int'(!NCT);
      nld_cnt += int'(!NLD);
      if (DONE) begin ndone++; done_at = i; end
    end
  endtask

  initial begin
    #2 CLR = 1'b1;
    #2;
    chk("rst_nld", NLD, 1); chk("rst_nct", NCT, 1); chk("rst_nud", NUD, 0);
    chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0); chk("rst_pass", pass_cnt, 0); chk("rst_dout", d_out, 0);
    tick;
    CLR = 1'b0;
    tick;
    // up, single pass 3 -> 7; a START mid-pass must be ignored
    start_seq(0, 4'h3, 4'h7, 4'h0);
    chk("up_load_nld", NLD, 0); chk("up_load_q", q, 4'h3); chk("up_busy", BUSY, 1);
    nlow = 0; nld_cnt = 0; ndone = 0; done_at = -1;
    PRESET = 4'hC;
    for (int i = 1; i <= 8; i++) begin
      START = (i == 2);
      tick;
      qs[i] = q;
      nlow += int'(!NCT);
      if (DONE) begin ndone++; done_at = i; end
    end
    START = 1'b0;
    chk("up_q2", qs[2], 4'h4); chk("up_q4", qs[4], 4'h6); chk("up_q5", qs[5], 4'h7);
    chk("up_qend", q, 4'h7); chk("up_nct_low", nlow, 4); chk("up_done_at", done_at, 6);
    chk("up_ndone", ndone, 1); chk("up_pass", pass_cnt, 1); chk("up_idle", BUSY, 0);
    // down with wrap 1 -> E
    start_seq(1, 4'h1, 4'hE, 4'h0);
    chk("dn_nud", NUD, 1);
    run(6);
    chk("dn_q2", qs[2], 4'h0); chk("dn_q3", qs[3], 4'hF); chk("dn_qend", q, 4'hE);
    chk("dn_done_at", done_at, 5); chk("dn_pass", pass_cnt, 1);
    // three passes 0 -> 2
    start_seq(0, 4'h0, 4'h2, 4'h2);
    run(14);
    chk("lp_loads", nld_cnt + 1, 3); chk("lp_done_at", done_at, 12); chk("lp_ndone", ndone, 1);
    chk("lp_pass", pass_cnt, 3); chk("lp_q", q, 4'h2); chk("lp_q5", qs[5], 4'h0); chk("lp_q7", qs[7], 4'h2);
    // zero-length pass
    start_seq(0, 4'h5, 4'h5, 4'h0);
    run(4);
    chk("z_done_at", done_at, 2); chk("z_nct_low", nlow, 0); chk("z_q", q, 4'h5);
    // HOLD for 3 edges starting with Q=4, pass 2 -> 9
    start_seq(0, 4'h2, 4'h9, 4'h0);
    tick; tick; tick;
    chk("h_q4", q, 4'h4);
    HOLD = 1'b1;
    tick;
    tick; chk("h_q5a", q, 4'h5); chk("h_nct", NCT, 1);
    tick; chk("h_q5b", q, 4'h5);
    HOLD = 1'b0;
    tick; chk("h_q5c", q, 4'h5); chk("h_resume", NCT, 0);
    run(7);
    chk("h_done_at", done_at, 5); chk("h_qend", q, 4'h9);
    // ABORT at Q=6 while counting up 3 -> 9
    start_seq(0, 4'h3, 4'h9, 4'h0);
    for (int i = 0; i < 10 && q != 4'h6; i++) tick;
    chk("ab_reach6", q, 4'h6);
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("ab_busy", BUSY, 0); chk("ab_nct", NCT, 1); chk("ab_nld", NLD, 1); chk("ab_pass", pass_cnt, 0);
    run(3);
    chk("ab_ndone", ndone, 0); chk("ab_qkeep", q, 4'h7);
    // CLR during LOAD acts immediately and leaves Q alone
    start_seq(0, 4'hA, 4'hC, 4'h0);
    chk("clr_load_q", q, 4'hA); chk("clr_load_nld", NLD, 0);
    #1 CLR = 1'b1;
    #1;
    chk("clr_nld", NLD, 1); chk("clr_nct", NCT, 1); chk("clr_busy", BUSY, 0);
    chk("clr_dout", d_out, 0); chk("clr_q", q, 4'hA);
    tick;
    CLR = 1'b0;
    tick;
    chk("clr_idle", BUSY, 0); chk("clr_qhold", q, 4'hA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
